// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared opcodes, ALU-op encodings, state and class enums for the LEGv8 control slice
package legv8_pkg;

  // Full-width opcodes for Instruction[31:21]
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  // Partially-decoded opcodes: compare (opc & MASK) against the value
  localparam logic [10:0] OPC_CBZ_MASK = 11'b11111111000;
  localparam logic [10:0] OPC_CBZ      = 11'b10110100000;
  localparam logic [10:0] OPC_B_MASK   = 11'b11111100000;
  localparam logic [10:0] OPC_B        = 11'b00010100000;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_B, CLS_ILLEGAL
  } cls_t;

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// rtl/legv8_multicycle_ctrl_if.sv - instruction/data memory req/ack handshake bundle
interface legv8_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;
  logic mem_read;
  logic mem_write;

  modport master (
    output imem_req, dmem_req, mem_read, mem_write,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, mem_read, mem_write,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/legv8_opc_class.sv
// rtl/legv8_opc_class.sv - combinational Instruction[31:21] to instruction-class decoder
module legv8_opc_class
  import legv8_pkg::*;
#(
  parameter int OPC_W = 11
) (
  input  logic [OPC_W-1:0] opc,
  output cls_t             cls
);

  // Anything not in the supported subset falls through to CLS_ILLEGAL
  always_comb begin
    cls = CLS_ILLEGAL;
    if (opc == OPC_ADD || opc == OPC_SUB || opc == OPC_AND || opc == OPC_ORR)
      cls = CLS_R;
    else if (opc == OPC_LDUR)
      cls = CLS_LDUR;
    else if (opc == OPC_STUR)
      cls = CLS_STUR;
    else if ((opc & OPC_CBZ_MASK) == OPC_CBZ)
      cls = CLS_CBZ;
    else if ((opc & OPC_B_MASK) == OPC_B)
      cls = CLS_B;
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// rtl/legv8_multicycle_ctrl.sv - LEGv8 multi-cycle sequencer; LEGV8_CTRL_TRAP_EN halts on illegal opcodes
module legv8_multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int OPC_W = 11,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  legv8_multicycle_ctrl_if.master bus,
  input  logic [31:0]            instr,
  input  logic                   zero,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   reg2loc,
  output logic                   alu_src,
  output logic [1:0]             alu_op,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   illegal,
  output logic [CNT_W-1:0]       retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  cls_t   cls_q;
  cls_t   cls_d;
  logic   imem_req_q;
  logic   dmem_req_q;
  logic   mem_read_q;
  logic   mem_write_q;
  logic   fetch_done;
  logic   branch_taken;

  // Only the opcode field steers control; operand fields belong to the datapath
  wire unused_instr = ^instr[31-OPC_W:0];

  legv8_opc_class #(.OPC_W(OPC_W)) u_opc_class (
    .opc (instr[31 -: OPC_W]),
    .cls (cls_d)
  );

  assign bus.imem_req  = imem_req_q;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;

  // Fetch completes in the ack cycle; the req gate keeps a stray ack just after reset from loading IR
  assign fetch_done   = (state == ST_FETCH) && imem_req_q && bus.imem_ack;
  assign branch_taken = (state == ST_EXEC) &&
                        ((cls_q == CLS_B) || ((cls_q == CLS_CBZ) && zero));

  // PC/IR strobes and Data2 select are decoded from current state and class
  always_comb begin
    ir_write = fetch_done;
    pc_write = fetch_done || branch_taken;
    pc_src   = branch_taken;
    reg2loc  = 1'b0;
    if (state == ST_DECODE)
      reg2loc = (cls_d == CLS_STUR) || (cls_d == CLS_CBZ);
    else if (state == ST_EXEC || state == ST_MEM || state == ST_WB)
      reg2loc = (cls_q == CLS_STUR) || (cls_q == CLS_CBZ);
  end

  // Sequencer: next state, latched class, registered strobes and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      cls_q       <= CLS_NONE;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src     <= 1'b0;
      alu_op      <= ALU_ADD;
      mem_to_reg  <= 1'b0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
      retired     <= '0;
    end else begin
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src     <= 1'b0;
      alu_op      <= ALU_ADD;
      mem_to_reg  <= 1'b0;
      reg_write   <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (fetch_done) state <= ST_DECODE;
          else            imem_req_q <= 1'b1;
        end
        ST_DECODE: begin
          cls_q <= cls_d;
          case (cls_d)
            CLS_R: begin
              state  <= ST_EXEC;
              alu_op <= ALU_FUNCT;
            end
            CLS_LDUR, CLS_STUR: begin
              state   <= ST_EXEC;
              alu_src <= 1'b1;
            end
            CLS_CBZ: begin
              state  <= ST_EXEC;
              alu_op <= ALU_PASS_B;
            end
            CLS_B: state <= ST_EXEC;
            default: begin
              illegal <= 1'b1;
`ifdef LEGV8_CTRL_TRAP_EN
              state <= ST_HALT;
`else
              state      <= ST_FETCH;
              imem_req_q <= 1'b1;
`endif
            end
          endcase
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_R: begin
              state     <= ST_WB;
              reg_write <= 1'b1;
            end
            CLS_LDUR: begin
              state      <= ST_MEM;
              dmem_req_q <= 1'b1;
              mem_read_q <= 1'b1;
            end
            CLS_STUR: begin
              state       <= ST_MEM;
              dmem_req_q  <= 1'b1;
              mem_write_q <= 1'b1;
            end
            default: begin
              state      <= ST_FETCH;
              imem_req_q <= 1'b1;
              retired    <= retired + CNT_ONE;
            end
          endcase
        end
        ST_MEM: begin
          if (bus.dmem_ack) begin
            if (cls_q == CLS_LDUR) begin
              state      <= ST_WB;
              reg_write  <= 1'b1;
              mem_to_reg <= 1'b1;
            end else begin
              state      <= ST_FETCH;
              imem_req_q <= 1'b1;
              retired    <= retired + CNT_ONE;
            end
          end else begin
            dmem_req_q  <= 1'b1;
            mem_read_q  <= mem_read_q;
            mem_write_q <= mem_write_q;
          end
        end
        ST_WB: begin
          state      <= ST_FETCH;
          imem_req_q <= 1'b1;
          retired    <= retired + CNT_ONE;
        end
        ST_HALT: state <= ST_HALT;
        default: begin
          state      <= ST_FETCH;
          imem_req_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb/tb_legv8_multicycle_ctrl.sv - randomized scoreboard bench for legv8_multicycle_ctrl
module tb_legv8_multicycle_ctrl;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  typedef struct packed {
    logic        imem_req;
    logic        dmem_req;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg2loc;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        illegal;
    logic [31:0] retired;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        ia;
    logic        da;
    logic        z;
    logic [31:0] ins;
    exp_t        e;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] instr = '0;
  logic        ir_write, pc_write, pc_src, reg2loc, alu_src, mem_to_reg, reg_write, illegal;
  logic [1:0]  alu_op;
  logic [31:0] retired;

  stim_t       sq[$];
  exp_t        sbq[$];
  logic [31:0] m_cnt;
  logic        m_ill;
  int          n_total = 0;
  int          n_pass = 0;
  int          cyc_n = 0;

  legv8_multicycle_ctrl_if bus();

  legv8_multicycle_ctrl #(.OPC_W(11), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .instr      (instr),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg2loc    (reg2loc),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  function automatic logic [31:0] mk(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_R: begin
        case ($urandom_range(0, 3))
          0:       return {11'b10001011000, r[20:0]};
          1:       return {11'b11001011000, r[20:0]};
          2:       return {11'b10001010000, r[20:0]};
          default: return {11'b10101010000, r[20:0]};
        endcase
      end
      K_LD:  return {11'b11111000010, r[20:0]};
      K_ST:  return {11'b11111000000, r[20:0]};
      K_CBZ: return {8'b10110100, r[23:0]};
      K_B:   return {6'b000101, r[25:0]};
      default: begin
        case ($urandom_range(0, 3))
          0:       return {11'h7FF, r[20:0]};
          1:       return {11'h000, r[20:0]};
          2:       return {11'b10001011001, r[20:0]};
          default: return {11'b11111000001, r[20:0]};
        endcase
      end
    endcase
  endfunction

  // One clock of stimulus plus the outputs the reference expects during it
  task automatic cyc(input logic r, input logic ia, input logic da, input logic z,
                     input logic [31:0] ins, input exp_t e);
    stim_t v;
    e.retired = m_cnt;
    e.illegal = m_ill;
    v.rst = r; v.ia = ia; v.da = da; v.z = z; v.ins = ins; v.e = e;
    sq.push_back(v);
  endtask

  // n cycles of reset, then the quiet cycle before the first fetch request
  task automatic rst_cyc(input int n);
    m_cnt = '0;
    m_ill = 1'b0;
    for (int i = 0; i < n; i++) cyc(1'b1, rb(), rb(), rb(), $urandom, '0);
    cyc(1'b0, 1'b0, rb(), rb(), $urandom, '0);
  endtask

  // Reference: one instruction as fetch wait/ack, decode, execute, memory wait/ack, write-back
  task automatic gen(input int k, input logic [31:0] ins, input int di, input int dd,
                     input logic z, input int rst_mem);
    exp_t e;
    for (int i = 0; i < di; i++) begin
      e = '0; e.imem_req = 1'b1;
      cyc(1'b0, 1'b0, rb(), rb(), $urandom, e);
    end
    e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(1'b0, 1'b1, rb(), rb(), $urandom, e);

    e = '0; e.reg2loc = (k == K_ST || k == K_CBZ);
    cyc(1'b0, rb(), rb(), rb(), ins, e);
    if (k == K_ILL) begin
      m_ill = 1'b1;
`ifdef LEGV8_CTRL_TRAP_EN
      for (int i = 0; i < 20; i++) cyc(1'b0, rb(), rb(), rb(), $urandom, '0);
`endif
      return;
    end

    e = '0;
    case (k)
      K_R:   e.alu_op = 2'b10;
      K_LD:  e.alu_src = 1'b1;
      K_ST:  begin e.alu_src = 1'b1; e.reg2loc = 1'b1; end
      K_CBZ: begin e.alu_op = 2'b01; e.reg2loc = 1'b1; e.pc_write = z; e.pc_src = z; end
      default: begin e.pc_write = 1'b1; e.pc_src = 1'b1; end
    endcase
    cyc(1'b0, rb(), rb(), (k == K_CBZ) ? z : rb(), ins, e);
    if (k == K_CBZ || k == K_B) begin
      m_cnt = m_cnt + 32'd1;
      return;
    end

    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= dd; i++) begin
        if (i == rst_mem) begin
          rst_cyc(2);
          return;
        end
        e = '0; e.dmem_req = 1'b1; e.mem_read = (k == K_LD);
        e.mem_write = (k == K_ST); e.reg2loc = (k == K_ST);
        cyc(1'b0, rb(), (i == dd), rb(), ins, e);
      end
      if (k == K_ST) begin
        m_cnt = m_cnt + 32'd1;
        return;
      end
    end

    e = '0; e.reg_write = 1'b1; e.mem_to_reg = (k == K_LD);
    cyc(1'b0, rb(), rb(), rb(), ins, e);
    m_cnt = m_cnt + 32'd1;
  endtask

  // Monitor: every sampled cycle is matched against the oldest expected record
  always @(negedge clk) begin
    exp_t ew, ea;
    if (sbq.size() > 0) begin
      ew = sbq.pop_front();
      ea = {bus.imem_req, bus.dmem_req, ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op,
            bus.mem_read, bus.mem_write, mem_to_reg, reg_write, illegal, retired};
      n_total++;
      if (ea === ew) n_pass++;
      else $display("FAIL outputs cycle %0d got %h want %h", cyc_n, ea, ew);
      cyc_n++;
    end
  end

  initial begin
    stim_t v;
    int    k;
    int    kmax;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
`ifdef LEGV8_CTRL_TRAP_EN
    kmax = K_B;
`else
    kmax = K_ILL;
`endif
    rst_cyc(3);
    gen(K_R,   32'h8B020020, 0, 0, 1'b0, -1);
    gen(K_LD,  32'hF8400020, 0, 3, 1'b0, -1);
    gen(K_CBZ, mk(K_CBZ),    0, 0, 1'b1, -1);
    gen(K_CBZ, mk(K_CBZ),    1, 0, 1'b0, -1);
    gen(K_ST,  mk(K_ST),     2, 1, 1'b0, -1);
    gen(K_B,   mk(K_B),      0, 0, 1'b0, -1);
    for (int i = 0; i < 150; i++) begin
      k = int'($urandom_range(0, kmax));
      gen(k, mk(k), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb(), -1);
    end
    gen(K_LD,  mk(K_LD),     0, 5, 1'b0, 2);
    gen(K_R,   mk(K_R),      0, 0, 1'b0, -1);
    gen(K_ILL, 32'hFFE00000, 0, 0, 1'b0, -1);
`ifndef LEGV8_CTRL_TRAP_EN
    gen(K_R,   mk(K_R),      1, 0, 1'b0, -1);
`endif

    while (sq.size() > 0) begin
      v = sq.pop_front();
      @(posedge clk);
      #1;
      reset        = v.rst;
      bus.imem_ack = v.ia;
      bus.dmem_ack = v.da;
      zero         = v.z;
      instr        = v.ins;
      sbq.push_back(v.e);
    end
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
